// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - shared token codes, ALU opcodes and FSM state codes for the RPN controller
package rpn_pkg;

   localparam int DW_DEF = 10;

   localparam logic [6:0] TOK_ADD = 7'h40;
   localparam logic [6:0] TOK_SUB = 7'h41;
   localparam logic [6:0] TOK_MUL = 7'h42;
   localparam logic [6:0] TOK_END = 7'h7F;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_MUL = 2'd2
   } alu_op_e;

   localparam logic [3:0] ST_IDLE = 4'd0;
   localparam logic [3:0] ST_REQ  = 4'd1;
   localparam logic [3:0] ST_DEC  = 4'd2;
   localparam logic [3:0] ST_PUSH = 4'd3;
   localparam logic [3:0] ST_RD_B = 4'd4;
   localparam logic [3:0] ST_RD_A = 4'd5;
   localparam logic [3:0] ST_EXEC = 4'd6;
   localparam logic [3:0] ST_WB   = 4'd7;
   localparam logic [3:0] ST_RD_R = 4'd8;
   localparam logic [3:0] ST_OUT  = 4'd9;

   // Operator codes other than sub/mul fall back to add.
   function automatic alu_op_e tok_to_op(input logic [6:0] tok);
      case (tok)
         TOK_SUB: return ALU_SUB;
         TOK_MUL: return ALU_MUL;
         TOK_ADD: return ALU_ADD;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/rpn_sp_unit.sv
// rtl/rpn_sp_unit.sv - stack pointer with inc/dec/clear and occupancy flags
module rpn_sp_unit #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec,
   input  logic          clr,
   output logic [AW-1:0] ptr,
   output logic          empty,
   output logic          one,
   output logic          lt2,
   output logic          full
);

   localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
   localparam logic [AW:0] SP_TWO  = (AW+1)'(2);
   localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

   // One extra bit so that a completely full stack is distinguishable from empty.
   logic [AW:0] sp;

   always_ff @(posedge clk) begin
      if (rst)
         sp <= '0;
      else if (clr)
         sp <= '0;
      else if (inc)
         sp <= sp + SP_ONE;
      else if (dec)
         sp <= sp - SP_ONE;
   end

   assign ptr   = sp[AW-1:0];
   assign empty = (sp == '0);
   assign one   = (sp == SP_ONE);
   assign lt2   = (sp < SP_TWO);
   assign full  = (sp == SP_FULL);

endmodule

// File: rtl/rpn_stack_ctrl.sv
// rtl/rpn_stack_ctrl.sv - RPN evaluation sequencer: token handshake, stack RAM and ALU control
// Optional bound checking with error flag is enabled by defining STACK_GUARD_EN.
module rpn_stack_ctrl
   import rpn_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DW    = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [6:0]    variable,
   output logic          req,
   output logic          valid,
   output logic [DW-1:0] answer,
   output logic          stk_we,
   output logic [AW-1:0] stk_addr,
   output logic [DW-1:0] stk_wdata,
   input  logic [DW-1:0] stk_rdata,
   output logic [1:0]    alu_op,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   input  logic [DW-1:0] alu_y,
   output logic          err
);

`ifdef STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic [3:0]    state;
   logic [6:0]    tok_q;
   logic [DW-1:0] a_q;
   logic [DW-1:0] b_q;
   logic [DW-1:0] y_q;
   logic [DW-1:0] answer_q;
   logic          err_q;
   logic          abort_q;
   logic          first_q;

   logic [AW-1:0] ptr;
   logic [AW-1:0] ptr_m1;
   logic [AW-1:0] ptr_m2;
   logic          sp_empty;
   logic          sp_one;
   logic          sp_lt2;
   logic          sp_full;
   logic          sp_inc;
   logic          sp_dec;
   logic          sp_clr;

   logic          is_opnd;
   logic          is_end;
   logic          fault_raw;
   logic [DW-1:0] opnd_ext;
   logic [DW-1:0] out_val;

   assign is_opnd  = ~tok_q[6];
   assign is_end   = (tok_q == TOK_END);
   assign opnd_ext = {{(DW-6){1'b0}}, tok_q[5:0]};
   assign ptr_m1   = ptr - AW'(1);
   assign ptr_m2   = ptr - AW'(2);

   // Bound violation for the token just decoded; only acted on in guarded builds.
   assign fault_raw = is_opnd ? sp_full : (is_end ? ~sp_one : sp_lt2);

   // An aborted expression freezes the stack until its end token.
   assign sp_inc = (state == ST_PUSH) & ~abort_q;
   assign sp_dec = (state == ST_WB)   & ~abort_q;
   assign sp_clr = (state == ST_OUT);

   rpn_sp_unit #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_sp (
      .clk   (clk),
      .rst   (rst),
      .inc   (sp_inc),
      .dec   (sp_dec),
      .clr   (sp_clr),
      .ptr   (ptr),
      .empty (sp_empty),
      .one   (sp_one),
      .lt2   (sp_lt2),
      .full  (sp_full)
   );

   always_comb begin
      out_val = stk_rdata;
      if (err_q)
         out_val = '1;
      else if (sp_empty)
         out_val = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         tok_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         y_q      <= '0;
         answer_q <= '0;
         err_q    <= 1'b0;
         abort_q  <= 1'b0;
         first_q  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: state <= ST_REQ;
            ST_REQ: begin
               if (en) begin
                  tok_q <= variable;
                  state <= ST_DEC;
                  if (first_q) begin
                     err_q   <= 1'b0;
                     abort_q <= 1'b0;
                     first_q <= 1'b0;
                  end
               end
            end
            ST_DEC: begin
               if (GUARD && fault_raw) begin
                  err_q   <= 1'b1;
                  abort_q <= 1'b1;
               end
               if (is_opnd)
                  state <= ST_PUSH;
               else if (is_end)
                  state <= ST_RD_R;
               else
                  state <= ST_RD_B;
            end
            ST_PUSH: state <= ST_REQ;
            ST_RD_B: state <= ST_RD_A;
            ST_RD_A: begin
               b_q   <= stk_rdata;
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               a_q   <= stk_rdata;
               y_q   <= alu_y;
               state <= ST_WB;
            end
            ST_WB:   state <= ST_REQ;
            ST_RD_R: state <= ST_OUT;
            ST_OUT: begin
               answer_q <= out_val;
               first_q  <= 1'b1;
               state    <= ST_REQ;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      stk_we    = 1'b0;
      stk_addr  = '0;
      stk_wdata = '0;
      case (state)
         ST_PUSH: begin
            stk_we    = ~abort_q;
            stk_addr  = ptr;
            stk_wdata = opnd_ext;
         end
         ST_RD_B, ST_RD_R: stk_addr = ptr_m1;
         ST_RD_A:          stk_addr = ptr_m2;
         ST_WB: begin
            stk_we    = ~abort_q;
            stk_addr  = ptr_m2;
            stk_wdata = y_q;
         end
         default: ;
      endcase
   end

   assign req    = (state == ST_REQ);
   assign valid  = (state == ST_OUT);
   // The result is visible during the strobe cycle and held in answer_q afterwards.
   assign answer = valid ? out_val : answer_q;
   assign alu_op = tok_to_op(tok_q);
   assign alu_a  = (state == ST_EXEC) ? stk_rdata : a_q;
   assign alu_b  = b_q;
   assign err    = err_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// tb/tb_rpn_stack_ctrl.sv - directed and random self-checking bench for rpn_stack_ctrl
module tb_rpn_stack_ctrl;
   import rpn_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int DW    = 10;
   localparam int NRAND = 1000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic [6:0]    variable = '0;
   logic          req;
   logic          valid;
   logic [DW-1:0] answer;
   logic          stk_we;
   logic [AW-1:0] stk_addr;
   logic [DW-1:0] stk_wdata;
   logic [DW-1:0] stk_rdata;
   logic [1:0]    alu_op;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [DW-1:0] alu_y;
   logic          err;

   int n_checks = 0;
   int n_fail = 0;
   int n_valid = 0;
   int n_overlap = 0;
   int n_expect_valid = 0;
   logic [DW-1:0] got[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mem[DEPTH];

   rpn_stack_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .variable  (variable),
      .req       (req),
      .valid     (valid),
      .answer    (answer),
      .stk_we    (stk_we),
      .stk_addr  (stk_addr),
      .stk_wdata (stk_wdata),
      .stk_rdata (stk_rdata),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_y     (alu_y),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (stk_we) mem[stk_addr] <= stk_wdata;
      stk_rdata <= mem[stk_addr];
   end

   always_comb begin
      case (alu_op)
         2'd1:    alu_y = alu_a - alu_b;
         2'd2:    alu_y = alu_a * alu_b;
         default: alu_y = alu_a + alu_b;
      endcase
   end

   always @(negedge clk) begin
      if (valid) begin
         got.push_back(answer);
         n_valid++;
      end
      if (valid && req) n_overlap++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [6:0] t);
      int n;
      n = 0;
      while (!req && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req) check("req_wait", {31'b0, req}, 32'd1);
      variable = t;
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic req_low(output int lo);
      lo = 0;
      while (!req && lo < 30) begin
         @(negedge clk);
         lo++;
      end
   endtask

   task automatic expect_ans(input string tag, input logic [DW-1:0] exp);
      int n;
      n = 0;
      n_expect_valid++;
      while (got.size() == 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (got.size() == 0) check({tag, "_timeout"}, 32'(got.size()), 32'd1);
      else check(tag, 32'(got.pop_front()), 32'(exp));
   endtask

   function automatic logic [DW-1:0] model(input logic [6:0] t[$]);
      logic [DW-1:0] s[$];
      logic [DW-1:0] a, b, r;
      foreach (t[i]) begin
         if (!t[i][6]) begin
            r = DW'(t[i][5:0]);
            s.push_back(r);
         end else if (t[i] == TOK_END) begin
            return (s.size() == 0) ? '0 : s[$];
         end else begin
            b = s.pop_back();
            a = s.pop_back();
            case (t[i])
               TOK_SUB: r = a - b;
               TOK_MUL: r = a * b;
               default: r = a + b;
            endcase
            s.push_back(r);
         end
      end
      return '0;
   endfunction

   function automatic logic [6:0] rand_opnd();
      return {1'b0, 6'($urandom_range(0, 63))};
   endfunction

   function automatic logic [6:0] rand_op();
      case ($urandom_range(0, 3))
         0: return TOK_ADD;
         1: return TOK_SUB;
         2: return TOK_MUL;
         default: return 7'($urandom_range(7'h43, 7'h7E));
      endcase
   endfunction

   initial begin
      int lo;
      int n;
      int mode;
      int w;
      logic [6:0] t[$];

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_req", {31'b0, req}, 32'd0);
      check("rst_valid", {31'b0, valid}, 32'd0);
      check("rst_answer", 32'(answer), 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_we", {31'b0, stk_we}, 32'd0);
      check("rst_addr", 32'(stk_addr), 32'd0);
      check("rst_wdata", 32'(stk_wdata), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_b", 32'(alu_b), 32'd0);
      rst = 1'b0;

      // 3 4 + end, with handshake timing
      send(7'd3);
      req_low(lo);
      check("opnd_en_to_req_3", 32'(lo + 1), 32'd3);
      send(7'd4);
      req_low(lo);
      check("opnd_en_to_req_4", 32'(lo + 1), 32'd3);
      send(TOK_ADD);
      req_low(lo);
      check("op_req_low", 32'(lo), 32'd5);
      send(TOK_END);
      expect_ans("add_3_4", 10'd7);

      send(7'd5); send(7'd2); send(TOK_SUB); send(TOK_END);
      expect_ans("sub_5_2", 10'd3);
      send(7'd2); send(7'd5); send(TOK_SUB); send(TOK_END);
      expect_ans("sub_wrap", 10'h3FD);
      send(7'd2); send(7'd3); send(TOK_MUL); send(7'd4); send(TOK_ADD); send(TOK_END);
      expect_ans("mul_add", 10'd10);
      send(7'd63); send(7'd63); send(TOK_MUL); send(TOK_END);
      expect_ans("mul_trunc", 10'd897);
      repeat (3) @(negedge clk);
      check("answer_held", 32'(answer), 32'd897);

      send(7'd1); send(7'd2); send(7'h55); send(TOK_END);
      expect_ans("unknown_op_add", 10'd3);

      // en raised while req is low must not be taken
      send(7'd8);
      variable = TOK_END;
      en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      en = 1'b0;
      send(7'd1); send(TOK_ADD); send(TOK_END);
      expect_ans("ignore_en_busy", 10'd9);

`ifdef STACK_GUARD_EN
      send(TOK_ADD); send(TOK_END);
      expect_ans("guard_underflow", 10'h3FF);
      check("guard_err_set", {31'b0, err}, 32'd1);
      send(7'd1);
      check("guard_err_clear", {31'b0, err}, 32'd0);
      send(7'd1); send(TOK_ADD); send(TOK_END);
      expect_ans("guard_recover", 10'd2);
      check("guard_err_stays_clear", {31'b0, err}, 32'd0);
      send(TOK_END);
      expect_ans("guard_end_empty", 10'h3FF);
`else
      send(TOK_END);
      expect_ans("end_empty", 10'd0);
      check("err_tied_low", {31'b0, err}, 32'd0);
`endif

      // Reset while the operator is in EXEC
      send(7'd9); send(7'd9); send(TOK_ADD);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_req", {31'b0, req}, 32'd0);
      check("midrst_valid", {31'b0, valid}, 32'd0);
      rst = 1'b0;
      send(7'd6); send(TOK_END);
      expect_ans("after_midrst", 10'd6);

      // Back-to-back random expressions against the model
      for (int e = 0; e < NRAND; e++) begin
         t.delete();
         n = $urandom_range(1, 4);
         mode = $urandom_range(0, 1);
         if (mode == 0) begin
            t.push_back(rand_opnd());
            for (int k = 1; k < n; k++) begin
               t.push_back(rand_opnd());
               t.push_back(rand_op());
            end
         end else begin
            for (int k = 0; k < n; k++) t.push_back(rand_opnd());
            for (int k = 1; k < n; k++) t.push_back(rand_op());
         end
         t.push_back(TOK_END);
         exp_q.push_back(model(t));
         foreach (t[i]) send(t[i]);
      end
      n_expect_valid += NRAND;
      w = 0;
      while (got.size() < NRAND && w < 5000) begin
         @(negedge clk);
         w++;
      end
      check("rand_count", 32'(got.size()), 32'(NRAND));
      for (int i = 0; i < NRAND; i++) begin
         if (got.size() > 0) check($sformatf("rand_%0d", i), 32'(got.pop_front()), 32'(exp_q[i]));
      end

      repeat (5) @(negedge clk);
      check("valid_req_overlap", 32'(n_overlap), 32'd0);
      check("valid_total", 32'(n_valid), 32'(n_expect_valid));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
